llc_request_issuer: RTL and testbench
=====================================

LLC_REQUEST_ISSUER -- requirements
Module: llc_request_issuer

Interface
REQ-001 SHALL have parameter PADDR_BITS, default 19, meaning physical address width.
REQ-002 SHALL have parameter W, default 64, meaning data word width.
REQ-003 SHALL have parameter Q_DEPTH, default 4, meaning request queue entries (power of 2).
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning max cycles waiting for a read response.
REQ-005 SHALL use one clock and an asynchronous active-low reset, ports: clk_in  in  1  clock; rst_N_in  in  1  async active-low reset.
REQ-006 SHALL have client ports: req_valid_in  in  1; req_ready_out  out  1; req_addr_in  in  PADDR_BITS; req_we_in  in  1; req_value_in  in  W.
REQ-007 SHALL have response ports: rsp_valid_out  out  1; rsp_ready_in  in  1; rsp_addr_out  out  PADDR_BITS; rsp_value_out  out  W.
REQ-008 SHALL have LLC request ports: cs_out  out  1; flush_out  out  1; hc_valid_out  out  1; hc_ready_in  in  1; hc_addr_out  out  PADDR_BITS; hc_value_out  out  W; hc_we_out  out  1; hc_line_out  out  512; hc_cl_out  out  1.
REQ-009 SHALL have LLC response ports: hc_valid_in  in  1; hc_ready_out  out  1; hc_addr_in  in  PADDR_BITS; hc_value_in  in  W.
REQ-010 SHALL have status ports: busy_out  out  1  (queue non-empty or FSM not IDLE); err_out  out  1  (sticky error).

Function
REQ-011 SHALL enqueue a request on req_valid_in & req_ready_out; req_ready_out = queue not full.
REQ-012 SHALL hold cs_out=1, flush_out=0, hc_cl_out=0, hc_line_out=0 at all times (word operations only).
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, DELIVER.
REQ-014 IDLE: if queue non-empty, pop head into the issue register and go to ISSUE next cycle.
REQ-015 ISSUE: drive hc_valid_out=1 with the registered addr/value/we; hold all fields stable until hc_ready_in=1.
REQ-016 On handshake in ISSUE: a write returns to IDLE; a read goes to WAIT_RSP and clears the timeout counter.
REQ-017 WAIT_RSP: hc_ready_out=1; on hc_valid_in with hc_addr_in equal to the issued address, capture hc_value_in and go to DELIVER.
REQ-018 WAIT_RSP: hc_valid_in with a mismatched address SHALL be consumed and discarded, set err_out, and leave the state unchanged.
REQ-019 WAIT_RSP: if the counter reaches TIMEOUT-1 without a match, set err_out, go to DELIVER with rsp_value_out = all ones.
REQ-020 DELIVER: rsp_valid_out=1 with the captured addr/value held stable; on rsp_ready_in go to IDLE.
REQ-021 hc_ready_out SHALL be 0 outside WAIT_RSP; hc_valid_out SHALL be 0 outside ISSUE.
REQ-022 Only one LLC transaction SHALL be outstanding; requests are issued in strict FIFO order.
REQ-023 Enqueue and pop in the same cycle on a full queue SHALL NOT be allowed (ready reflects the pre-pop state); on a non-full queue both SHALL take effect.
REQ-024 Queue pointers SHALL wrap modulo Q_DEPTH, with a count of log2(Q_DEPTH)+1 bits.
REQ-025 Minimum write latency from enqueue into an empty queue to hc_valid_out SHALL be 2 cycles.

Reset
REQ-026 Asserting rst_N_in low SHALL immediately set: FSM=IDLE; queue empty; all valid/ready outputs 0 except cs_out=1; addr/value outputs 0; err_out=0; busy_out=0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no response delivered.
REQ-028 After release, req_ready_out SHALL rise on the first clock edge.

Structure
REQ-029 Package llc_issuer_pkg SHALL hold the state enum and the request struct (addr, we, value).
REQ-030 The queue SHALL be the sub-module llc_req_fifo (parameterised depth, width = request struct).

Verification
REQ-031 Write 0x1_2340 data 0xDEAD_BEEF, hc_ready_in=1 -> hc_valid_out 2 cycles after enqueue, we=1, no rsp_valid_out.
REQ-032 Read 0x00040, LLC replies after 30 cycles with addr 0x00040 value 0x55 -> rsp_valid_out with 0x55; err_out=0.
REQ-033 Five back-to-back requests, hc_ready_in=0 -> req_ready_out drops after the 4th is queued or issued; order preserved on release.
REQ-034 Read, LLC replies with a wrong address and then the right one -> err_out=1; the correct value is delivered.
REQ-035 Read, no reply -> after TIMEOUT cycles rsp_value_out=all ones, err_out=1.
REQ-036 Reset asserted in WAIT_RSP -> all outputs reach reset values without a clock; no stale response after release.

Source files
------------

// File: rtl/llc_issuer_pkg.sv
// Shared types for the LLC request issuer: FSM state encoding, the queued
// request record, and a small sizing helper.
package llc_issuer_pkg;

   // Widest address / data the queued request record can carry. Narrower
   // instances zero-extend into these fields; W must not exceed REQ_DATA_MAX.
   localparam int unsigned REQ_ADDR_MAX = 64;
   localparam int unsigned REQ_DATA_MAX = 64;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DELIVER  = 2'd3
   } state_e;

   typedef struct packed {
      logic [REQ_ADDR_MAX-1:0] addr;
      logic                    we;
      logic [REQ_DATA_MAX-1:0] value;
   } req_t;

   localparam int unsigned REQ_BITS = $bits(req_t);

   // Pointer width for a power-of-two queue; never below one bit.
   function automatic int unsigned ptr_bits(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/llc_req_fifo.sv
// Request queue: power-of-two circular buffer with an occupancy counter.
// A push on a full queue is dropped even if a pop happens in the same cycle,
// so the producer-facing "full" is always the pre-pop view.
module llc_req_fifo
   import llc_issuer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = REQ_BITS
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = ptr_bits(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset empties the queue immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/llc_request_issuer.sv
// Serialises client word requests onto the LLC port, one transaction at a
// time in FIFO order. Reads wait for an address-matched reply (bounded by
// TIMEOUT) and are returned on the response port; writes complete on the
// request handshake alone.
module llc_request_issuer
   import llc_issuer_pkg::*;
#(
   parameter int unsigned PADDR_BITS = 19,
   parameter int unsigned W          = 64,
   parameter int unsigned Q_DEPTH    = 4,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic                  clk_in,
   input  logic                  rst_N_in,
   // client requests
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic [PADDR_BITS-1:0] req_addr_in,
   input  logic                  req_we_in,
   input  logic [W-1:0]          req_value_in,
   // client responses
   output logic                  rsp_valid_out,
   input  logic                  rsp_ready_in,
   output logic [PADDR_BITS-1:0] rsp_addr_out,
   output logic [W-1:0]          rsp_value_out,
   // LLC request channel
   output logic                  cs_out,
   output logic                  flush_out,
   output logic                  hc_valid_out,
   input  logic                  hc_ready_in,
   output logic [PADDR_BITS-1:0] hc_addr_out,
   output logic [W-1:0]          hc_value_out,
   output logic                  hc_we_out,
   output logic [511:0]          hc_line_out,
   output logic                  hc_cl_out,
   // LLC response channel
   input  logic                  hc_valid_in,
   output logic                  hc_ready_out,
   input  logic [PADDR_BITS-1:0] hc_addr_in,
   input  logic [W-1:0]          hc_value_in,
   // status
   output logic                  busy_out,
   output logic                  err_out
);

   localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e          state_q, state_d;
   req_t            enq_req, head_req;
   req_t            iss_q, iss_d;
   logic [W-1:0]    rsp_val_q, rsp_val_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            err_q, err_d;
   logic            rdy_en_q;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [REQ_BITS-1:0] fifo_rdata;
   logic            addr_match;

   // Pack the client request into the queue record, zero-extending fields.
   always_comb begin
      enq_req       = '0;
      enq_req.addr  = REQ_ADDR_MAX'(req_addr_in);
      enq_req.we    = req_we_in;
      enq_req.value = REQ_DATA_MAX'(req_value_in);
   end

   // Ready is held low through reset and rises on the first edge after it.
   assign req_ready_out = rdy_en_q & ~fifo_full;
   assign fifo_push     = req_valid_in & req_ready_out;
   assign head_req      = fifo_rdata;

   llc_req_fifo #(
      .DEPTH (Q_DEPTH),
      .WIDTH (REQ_BITS)
   ) u_fifo (
      .clk_i   (clk_in),
      .rst_ni  (rst_N_in),
      .push_i  (fifo_push),
      .wdata_i (enq_req),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Replies are matched on the full stored address, so compare zero-extended.
   assign addr_match = (iss_q.addr == REQ_ADDR_MAX'(hc_addr_in));

   // Transaction FSM next-state: issue, await reply or timeout, deliver.
   always_comb begin
      state_d   = state_q;
      iss_d     = iss_q;
      rsp_val_d = rsp_val_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      fifo_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               iss_d    = head_req;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (hc_ready_in) begin
               if (iss_q.we) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT_RSP;
                  tmo_d   = '0;
               end
            end
         end
         ST_WAIT_RSP: begin
            if (hc_valid_in && addr_match) begin
               rsp_val_d = hc_value_in;
               state_d   = ST_DELIVER;
            end else begin
               // A stray reply is swallowed and flagged; the wait goes on.
               if (hc_valid_in) err_d = 1'b1;
               if (tmo_q == TMO_LAST) begin
                  err_d     = 1'b1;
                  rsp_val_d = '1;
                  state_d   = ST_DELIVER;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
         end
         ST_DELIVER: begin
            if (rsp_ready_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         state_q   <= ST_IDLE;
         iss_q     <= '0;
         rsp_val_q <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         iss_q     <= iss_d;
         rsp_val_q <= rsp_val_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         rdy_en_q  <= 1'b1;
      end
   end

   // Word-only access: line transfers and flushes are never used.
   assign cs_out       = 1'b1;
   assign flush_out    = 1'b0;
   assign hc_cl_out    = 1'b0;
   assign hc_line_out  = '0;

   assign hc_valid_out  = (state_q == ST_ISSUE);
   assign hc_addr_out   = iss_q.addr[PADDR_BITS-1:0];
   assign hc_value_out  = iss_q.value[W-1:0];
   assign hc_we_out     = iss_q.we;
   assign hc_ready_out  = (state_q == ST_WAIT_RSP);

   assign rsp_valid_out = (state_q == ST_DELIVER);
   assign rsp_addr_out  = iss_q.addr[PADDR_BITS-1:0];
   assign rsp_value_out = rsp_val_q;

   assign busy_out = ~fifo_empty | (state_q != ST_IDLE);
   assign err_out  = err_q;

endmodule

// File: tb/tb_llc_request_issuer.sv
// Directed bench for llc_request_issuer: reset, write, read, back-to-back,
// stray reply, timeout and mid-transaction reset scenarios.
module tb_llc_request_issuer;

   localparam int PA  = 19;
   localparam int DW  = 64;
   localparam int TMO = 64;

   logic            clk_in = 1'b0;
   logic            rst_N_in = 1'b1;
   logic            req_valid_in = 1'b0;
   logic            req_ready_out;
   logic [PA-1:0]   req_addr_in = '0;
   logic            req_we_in = 1'b0;
   logic [DW-1:0]   req_value_in = '0;
   logic            rsp_valid_out;
   logic            rsp_ready_in = 1'b0;
   logic [PA-1:0]   rsp_addr_out;
   logic [DW-1:0]   rsp_value_out;
   logic            cs_out, flush_out, hc_valid_out;
   logic            hc_ready_in = 1'b0;
   logic [PA-1:0]   hc_addr_out;
   logic [DW-1:0]   hc_value_out;
   logic            hc_we_out;
   logic [511:0]    hc_line_out;
   logic            hc_cl_out;
   logic            hc_valid_in = 1'b0;
   logic            hc_ready_out;
   logic [PA-1:0]   hc_addr_in = '0;
   logic [DW-1:0]   hc_value_in = '0;
   logic            busy_out, err_out;

   int tests = 0;
   int fails = 0;

   llc_request_issuer #(
      .PADDR_BITS(PA), .W(DW), .Q_DEPTH(4), .TIMEOUT(TMO)
   ) dut (
      .clk_in(clk_in), .rst_N_in(rst_N_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_addr_in(req_addr_in), .req_we_in(req_we_in), .req_value_in(req_value_in),
      .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
      .rsp_addr_out(rsp_addr_out), .rsp_value_out(rsp_value_out),
      .cs_out(cs_out), .flush_out(flush_out), .hc_valid_out(hc_valid_out),
      .hc_ready_in(hc_ready_in), .hc_addr_out(hc_addr_out), .hc_value_out(hc_value_out),
      .hc_we_out(hc_we_out), .hc_line_out(hc_line_out), .hc_cl_out(hc_cl_out),
      .hc_valid_in(hc_valid_in), .hc_ready_out(hc_ready_out),
      .hc_addr_in(hc_addr_in), .hc_value_in(hc_value_in),
      .busy_out(busy_out), .err_out(err_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick;
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   // Present one request for a single cycle (ready is known to be high).
   task automatic send(input logic [PA-1:0] a, input logic we, input logic [DW-1:0] v);
      req_valid_in = 1'b1; req_addr_in = a; req_we_in = we; req_value_in = v;
      tick;
      req_valid_in = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge clk_in);
      rst_N_in = 1'b0;
      tick;
      rst_N_in = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      #1 rst_N_in = 1'b0;
      #2;
      tests++;
      if ({req_ready_out, rsp_valid_out, hc_valid_out, hc_ready_out, busy_out, err_out} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags got %b want 000000",
                  {req_ready_out, rsp_valid_out, hc_valid_out, hc_ready_out, busy_out, err_out});
      end
      tests++;
      if ({cs_out, flush_out, hc_cl_out} !== 3'b100) begin
         fails++; $display("FAIL reset_static got %b want 100", {cs_out, flush_out, hc_cl_out});
      end
      tests++;
      if (hc_line_out !== 512'd0) begin
         fails++; $display("FAIL reset_line got %0h want 0", hc_line_out);
      end
      tests++;
      if ({hc_addr_out, rsp_addr_out, hc_value_out, rsp_value_out, hc_we_out} !== '0) begin
         fails++; $display("FAIL reset_data got %h %h %h %h want 0", hc_addr_out, rsp_addr_out,
                           hc_value_out, rsp_value_out);
      end
      repeat (2) @(negedge clk_in);
      rst_N_in = 1'b1;
      #1;
      tests++;
      if (req_ready_out !== 1'b0) begin
         fails++; $display("FAIL release_ready_early got %b want 0", req_ready_out);
      end
      @(negedge clk_in);
      tests++;
      if (req_ready_out !== 1'b1) begin
         fails++; $display("FAIL release_ready_first_edge got %b want 1", req_ready_out);
      end
   endtask

   task automatic test_write;
      bit seen = 0;
      hc_ready_in = 1'b1;
      send(19'h12340, 1'b1, 64'hDEAD_BEEF);
      tests++;
      if (hc_valid_out !== 1'b0) begin
         fails++; $display("FAIL write_lat1 got %b want 0", hc_valid_out);
      end
      tick;
      tests++;
      if (hc_valid_out !== 1'b1) begin
         fails++; $display("FAIL write_lat2 got %b want 1", hc_valid_out);
      end
      tests++;
      if ({hc_we_out, hc_addr_out, hc_value_out} !== {1'b1, 19'h12340, 64'hDEAD_BEEF}) begin
         fails++; $display("FAIL write_fields got we=%b a=%h v=%h want 1 12340 deadbeef",
                           hc_we_out, hc_addr_out, hc_value_out);
      end
      repeat (4) begin
         tick;
         if (rsp_valid_out) seen = 1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++; $display("FAIL write_no_rsp got %b want 0", seen);
      end
      tests++;
      if ({hc_valid_out, busy_out, err_out} !== 3'b000) begin
         fails++; $display("FAIL write_done got %b want 000", {hc_valid_out, busy_out, err_out});
      end
      hc_ready_in = 1'b0;
   endtask

   task automatic test_read;
      bit bad = 0;
      hc_ready_in = 1'b1;
      send(19'h00040, 1'b0, '0);
      tick;
      tests++;
      if ({hc_valid_out, hc_we_out, hc_addr_out} !== {1'b1, 1'b0, 19'h00040}) begin
         fails++; $display("FAIL read_issue got v=%b we=%b a=%h want 1 0 00040",
                           hc_valid_out, hc_we_out, hc_addr_out);
      end
      tick;
      hc_ready_in = 1'b0;
      tests++;
      if ({hc_ready_out, hc_valid_out} !== 2'b10) begin
         fails++; $display("FAIL read_wait got %b want 10", {hc_ready_out, hc_valid_out});
      end
      repeat (29) begin
         tick;
         if (rsp_valid_out || !hc_ready_out) bad = 1;
      end
      tests++;
      if (bad !== 1'b0) begin
         fails++; $display("FAIL read_hold_wait got %b want 0", bad);
      end
      hc_valid_in = 1'b1; hc_addr_in = 19'h00040; hc_value_in = 64'h55;
      tick;
      hc_valid_in = 1'b0;
      tests++;
      if ({rsp_valid_out, rsp_addr_out, rsp_value_out} !== {1'b1, 19'h00040, 64'h55}) begin
         fails++; $display("FAIL read_rsp got v=%b a=%h d=%h want 1 00040 55",
                           rsp_valid_out, rsp_addr_out, rsp_value_out);
      end
      tests++;
      if ({err_out, hc_ready_out} !== 2'b00) begin
         fails++; $display("FAIL read_err got %b want 00", {err_out, hc_ready_out});
      end
      tick;
      tests++;
      if ({rsp_valid_out, rsp_value_out} !== {1'b1, 64'h55}) begin
         fails++; $display("FAIL read_rsp_stall got v=%b d=%h want 1 55", rsp_valid_out, rsp_value_out);
      end
      rsp_ready_in = 1'b1;
      tick;
      rsp_ready_in = 1'b0;
      tests++;
      if ({rsp_valid_out, busy_out} !== 2'b00) begin
         fails++; $display("FAIL read_done got %b want 00", {rsp_valid_out, busy_out});
      end
   endtask

   task automatic test_back_to_back;
      int n = 0;
      hc_ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req_valid_in = 1'b1; req_we_in = 1'b1;
         req_addr_in = PA'(32'h100 + i); req_value_in = DW'(i + 1);
         tests++;
         if (req_ready_out !== 1'b1) begin
            fails++; $display("FAIL b2b_ready_%0d got %b want 1", i, req_ready_out);
         end
         tick;
      end
      req_valid_in = 1'b0;
      tests++;
      if (req_ready_out !== 1'b0) begin
         fails++; $display("FAIL b2b_full got %b want 0", req_ready_out);
      end
      repeat (3) tick;
      tests++;
      if ({hc_valid_out, hc_addr_out, req_ready_out, busy_out} !== {1'b1, 19'h100, 1'b0, 1'b1}) begin
         fails++; $display("FAIL b2b_stall got v=%b a=%h rdy=%b busy=%b want 1 100 0 1",
                           hc_valid_out, hc_addr_out, req_ready_out, busy_out);
      end
      hc_ready_in = 1'b1;
      for (int c = 0; c < 40 && n < 5; c++) begin
         if (hc_valid_out) begin
            tests++;
            if ({hc_addr_out, hc_value_out} !== {PA'(32'h100 + n), DW'(n + 1)}) begin
               fails++; $display("FAIL b2b_order_%0d got a=%h d=%h want a=%h d=%h", n,
                                 hc_addr_out, hc_value_out, PA'(32'h100 + n), DW'(n + 1));
            end
            n++;
         end
         tick;
      end
      hc_ready_in = 1'b0;
      tests++;
      if (n !== 5) begin
         fails++; $display("FAIL b2b_count got %0d want 5", n);
      end
      tests++;
      if ({busy_out, req_ready_out} !== 2'b01) begin
         fails++; $display("FAIL b2b_drained got %b want 01", {busy_out, req_ready_out});
      end
   endtask

   task automatic test_bad_addr;
      hc_ready_in = 1'b1;
      send(19'h00200, 1'b0, '0);
      tick;
      tick;
      hc_ready_in = 1'b0;
      tests++;
      if ({hc_ready_out, err_out} !== 2'b10) begin
         fails++; $display("FAIL bad_wait got %b want 10", {hc_ready_out, err_out});
      end
      hc_valid_in = 1'b1; hc_addr_in = 19'h00204; hc_value_in = 64'h99;
      tick;
      hc_valid_in = 1'b0;
      tests++;
      if ({err_out, hc_ready_out, rsp_valid_out} !== 3'b110) begin
         fails++; $display("FAIL bad_discard got %b want 110", {err_out, hc_ready_out, rsp_valid_out});
      end
      tick;
      hc_valid_in = 1'b1; hc_addr_in = 19'h00200; hc_value_in = 64'h77;
      tick;
      hc_valid_in = 1'b0;
      tests++;
      if ({rsp_valid_out, rsp_value_out, err_out} !== {1'b1, 64'h77, 1'b1}) begin
         fails++; $display("FAIL bad_then_good got v=%b d=%h err=%b want 1 77 1",
                           rsp_valid_out, rsp_value_out, err_out);
      end
      rsp_ready_in = 1'b1;
      tick;
      rsp_ready_in = 1'b0;
   endtask

   task automatic test_timeout;
      int n = 0;
      do_reset;
      tests++;
      if (err_out !== 1'b0) begin
         fails++; $display("FAIL tmo_err_cleared got %b want 0", err_out);
      end
      hc_ready_in = 1'b1;
      send(19'h00300, 1'b0, '0);
      tick;
      tick;
      hc_ready_in = 1'b0;
      while (hc_ready_out && n < 200) begin
         n++;
         tick;
      end
      tests++;
      if (n !== TMO) begin
         fails++; $display("FAIL tmo_cycles got %0d want %0d", n, TMO);
      end
      tests++;
      if ({rsp_valid_out, rsp_addr_out, rsp_value_out, err_out} !== {1'b1, 19'h00300, {DW{1'b1}}, 1'b1}) begin
         fails++; $display("FAIL tmo_rsp got v=%b a=%h d=%h err=%b want 1 00300 all-ones 1",
                           rsp_valid_out, rsp_addr_out, rsp_value_out, err_out);
      end
      rsp_ready_in = 1'b1;
      tick;
      rsp_ready_in = 1'b0;
   endtask

   task automatic test_reset_mid;
      bit seen = 0;
      hc_ready_in = 1'b1;
      send(19'h00400, 1'b0, '0);
      tick;
      tick;
      hc_ready_in = 1'b0;
      tests++;
      if ({hc_ready_out, busy_out, err_out} !== 3'b111) begin
         fails++; $display("FAIL mid_pre got %b want 111", {hc_ready_out, busy_out, err_out});
      end
      #2 rst_N_in = 1'b0;
      #1;
      tests++;
      if ({hc_ready_out, busy_out, err_out, req_ready_out, rsp_valid_out, hc_valid_out} !== 6'b0) begin
         fails++; $display("FAIL mid_async got %b want 000000",
                           {hc_ready_out, busy_out, err_out, req_ready_out, rsp_valid_out, hc_valid_out});
      end
      tests++;
      if ({hc_addr_out, rsp_value_out} !== '0) begin
         fails++; $display("FAIL mid_async_data got a=%h d=%h want 0 0", hc_addr_out, rsp_value_out);
      end
      @(negedge clk_in);
      hc_valid_in = 1'b1; hc_addr_in = 19'h00400; hc_value_in = 64'h11;
      rst_N_in = 1'b1;
      repeat (5) begin
         tick;
         if (rsp_valid_out || hc_ready_out) seen = 1;
      end
      hc_valid_in = 1'b0;
      tests++;
      if ({seen, err_out, busy_out} !== 3'b000) begin
         fails++; $display("FAIL mid_no_stale got %b want 000", {seen, err_out, busy_out});
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_back_to_back;
      test_bad_addr;
      test_timeout;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "bench did not complete");
   end

endmodule
